// File: rtl/alu_writeback.sv
// Writeback stage: buffers tagged ALU results in a small FIFO and commits them
// one at a time into a register file with a registered, read-first read port.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting; pops the FIFO head into staging when data is pending
// COMMIT | staged result is written to the register file at this edge
module alu_writeback #(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 4,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [RADDR_W-1:0] in_reg_addr,
  output logic               in_ready,
  input  logic               flush,
  input  logic [RADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic [2:0]         level,
  output logic               wb_state,
  output logic [7:0]         wr_count,
  output logic               busy,
  output logic               overflow
);

  localparam int         PTR_W    = $clog2(DEPTH);
  localparam int         NREG     = 1 << RADDR_W;
  localparam logic [2:0] LVL_FULL = 3'(DEPTH);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_COMMIT = 1'b1;

  logic [RADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0]  fifo_data [DEPTH];
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [2:0]         level_q;
  logic [0:0]         state_q;
  logic [RADDR_W-1:0] stg_addr;
  logic [DATA_W-1:0]  stg_data;
  logic [7:0]         wr_count_q;
  logic               overflow_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic [DATA_W-1:0]  regfile [NREG];

  logic push;
  logic pop;
  logic commit;

  // Readiness looks only at the current level: a same-cycle pop never makes room.
  assign in_ready = (level_q != LVL_FULL) && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == S_IDLE) && (level_q != 3'd0) && !flush;
  assign commit   = (state_q == S_COMMIT) && !flush;

  assign level    = level_q;
  assign wb_state = state_q[0];
  assign wr_count = wr_count_q;
  assign busy     = (level_q != 3'd0) || (state_q == S_COMMIT);
  assign overflow = overflow_q;
  assign rd_data  = rd_data_q;

  // FIFO storage carries no reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[tail_q] <= in_reg_addr;
      fifo_data[tail_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= 3'd0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= 3'd0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + 3'd1;
        2'b01:   level_q <= level_q - 3'd1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      stg_addr <= '0;
      stg_data <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            stg_addr <= fifo_addr[head_q];
            stg_data <= fifo_data[head_q];
            state_q  <= S_COMMIT;
          end
        end
        S_COMMIT: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count_q <= 8'd0;
    end else if (commit) begin
      wr_count_q <= wr_count_q + 8'd1;
    end
  end

  // Sticky until reset; a dropped input during flush is not an overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (in_valid && !in_ready && !flush) begin
      overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regfile[i] <= '0;
    end else if (commit) begin
      regfile[stg_addr] <= stg_data;
    end
  end

  // Nonblocking read of the array gives read-first behaviour on a same-edge commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= regfile[rd_addr];
    end
  end

endmodule
